reg_file_mp: RTL

REG_FILE_MP -- requirements
Module: reg_file_mp

---
 rtl/reg_file_pkg.sv | 10 +
 rtl/reg_file_rport.sv | 51 +++++
 rtl/reg_file_mp.sv | 76 +++++++
 3 files changed

// File: rtl/reg_file_pkg.sv
// Shared defaults and select type for the multi-port register file.
package reg_file_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_SEL_BITS   = 5;
    localparam int DEF_NUM_READ   = 2;

    typedef logic [DEF_SEL_BITS-1:0] sel_t;

endpackage

// File: rtl/reg_file_rport.sv
// One registered read port: register-0 zeroing, optional write forwarding, busy lookup.
// Forwarding is enabled by defining REG_FILE_MP_BYPASS_EN.
module reg_file_rport #(
    parameter int REG_DATA_WIDTH = 32,
    parameter int REG_SEL_BITS   = 5
) (
    input  logic                                     clock,
    input  logic                                     reset,
    input  logic [REG_SEL_BITS-1:0]                  sel,
    input  logic [(2**REG_SEL_BITS)*REG_DATA_WIDTH-1:0] regs_flat,
    input  logic [(2**REG_SEL_BITS)-1:0]             busy_nxt,
    input  logic                                     wr_qual,
    input  logic [REG_SEL_BITS-1:0]                  write_sel,
    input  logic [REG_DATA_WIDTH-1:0]                write_data,
    output logic [REG_DATA_WIDTH-1:0]                rd_data,
    output logic                                     rd_busy
);

`ifdef REG_FILE_MP_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic signed [REG_DATA_WIDTH-1:0] data_p0;
    logic signed [REG_DATA_WIDTH-1:0] data_p1;
    logic                             busy_p1;

    always_comb begin
        data_p0 = regs_flat[int'(sel)*REG_DATA_WIDTH +: REG_DATA_WIDTH];
        if (BYPASS && wr_qual && (sel == write_sel))
            data_p0 = write_data;
        if (sel == '0)
            data_p0 = '0;
    end

    // p0 -> p1: registered read; busy sampled after this edge's set/clear
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_p1 <= '0;
            busy_p1 <= 1'b0;
        end else begin
            data_p1 <= data_p0;
            busy_p1 <= busy_nxt[sel];
        end
    end

    assign rd_data = data_p1;
    assign rd_busy = busy_p1;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with per-register pending-write (busy) tracking.
// Define REG_FILE_MP_BYPASS_EN for same-cycle write-to-read forwarding.
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int REG_DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int REG_SEL_BITS   = DEF_SEL_BITS,
    parameter int NUM_READ       = DEF_NUM_READ
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [NUM_READ*REG_SEL_BITS-1:0]   read_sel,
    output logic [NUM_READ*REG_DATA_WIDTH-1:0] read_data,
    input  logic                               wEn,
    input  logic [REG_SEL_BITS-1:0]            write_sel,
    input  logic [REG_DATA_WIDTH-1:0]          write_data,
    input  logic                               busy_set,
    input  logic [REG_SEL_BITS-1:0]            busy_sel,
    output logic [NUM_READ-1:0]                read_busy
);

    localparam int DEPTH = 2**REG_SEL_BITS;

    logic [REG_DATA_WIDTH-1:0]       regs [DEPTH];
    logic [DEPTH*REG_DATA_WIDTH-1:0] regs_flat;
    logic [DEPTH-1:0]                busy;
    logic [DEPTH-1:0]                busy_nxt;
    logic                            wr_qual;

    assign wr_qual = wEn && (write_sel != '0);

    // A write clears the pending flag; a coincident busy_set wins.
    always_comb begin
        busy_nxt = busy;
        if (wr_qual)
            busy_nxt[write_sel] = 1'b0;
        if (busy_set && (busy_sel != '0))
            busy_nxt[busy_sel] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                regs[i] <= '0;
            busy <= '0;
        end else begin
            if (wr_qual)
                regs[write_sel] <= write_data;
            busy <= busy_nxt;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_flat
        assign regs_flat[i*REG_DATA_WIDTH +: REG_DATA_WIDTH] = regs[i];
    end

    for (genvar k = 0; k < NUM_READ; k++) begin : g_rport
        reg_file_rport #(
            .REG_DATA_WIDTH (REG_DATA_WIDTH),
            .REG_SEL_BITS   (REG_SEL_BITS)
        ) u_rport (
            .clock      (clock),
            .reset      (reset),
            .sel        (read_sel[k*REG_SEL_BITS +: REG_SEL_BITS]),
            .regs_flat  (regs_flat),
            .busy_nxt   (busy_nxt),
            .wr_qual    (wr_qual),
            .write_sel  (write_sel),
            .write_data (write_data),
            .rd_data    (read_data[k*REG_DATA_WIDTH +: REG_DATA_WIDTH]),
            .rd_busy    (read_busy[k])
        );
    end

endmodule
